multibit_tree_tag_sorter: RTL and testbench
===========================================

// Module: multibit_tree_tag_sorter
// PURPOSE
//  Pipelined tag sorter for fair-queuing schedulers. Built on a 16-way multibit bitmap tree.
//  Each accepted tag is looked up against all previously accepted tags, then inserted.
//  The lookup returns the largest stored tag <= the incoming tag (the predecessor).
//  The scheduler uses that predecessor as the linked-list insertion point.
// PARAMETERS
//  T  12  tag width in bits; must be a multiple of 4; tree depth L = T/4 levels (3 at default)
// PORTS
//  clk                   in   1  single clock, all logic on rising edge
//  rst                   in   1  synchronous, active-high reset
//  ena                   in   1  accept incoming_tag this cycle (search + insert)
//  incoming_tag          in   T  tag to look up and insert
//  matching_tag          out  T  predecessor of the tag accepted L cycles earlier
//  incoming_tag_forward  out  T  that same accepted tag, delayed L cycles to align with matching_tag
// BEHAVIOUR
//  Reset and polarity:
//  - Reset is synchronous, active-high.
//  - rst clears every tree bitmap and all pipeline registers.
//  - matching_tag and incoming_tag_forward reset to 0.
//  Tree structure:
//  - Level k (k=0..L-1) holds 16^(k+1) bits, stored as 16^k 16-bit bitmaps.
//  - Level k is indexed by tag nibbles above level k; bit = nibble k, counting from the MSB nibble.
//  - Level L-1 bitmaps are leaves: one bit per possible tag value.
//  - A bit is set iff some stored tag has that prefix.
//  - Only rst clears bits; there is no delete. Duplicate inserts are idempotent.
//  - The tree persists across ena=0 gaps.
//  Search (per accepted tag X):
//  - One tree level per pipeline stage, MSB nibble first.
//  - Per level, take the highest set bit <= the current nibble (equal-prefix path).
//  - If the equal-prefix path dies, backtrack to the deepest level that has a set bit below
//    the path nibble.
//  - Below that level, follow the highest set bit (max descent).
//  - Result = largest stored tag <= X, including X itself if X was stored earlier.
//  - No stored tag <= X (incl. empty tree): matching_tag = X.
//  Ordering and latency:
//  - Semantics are strictly sequential in acceptance order.
//  - The search for a tag sees every tag accepted in earlier cycles, even back-to-back
//    or still in flight. Implement with bypass/forwarding or a read-after-write-safe pipeline.
//  - A tag never matches its own insertion; only a prior copy of X counts.
//  - Fixed latency L cycles: a tag accepted at edge n appears on both outputs after edge n+L.
//  - Full throughput: one tag per cycle, no stall, no backpressure.
//  ena behaviour:
//  - ena=0: no search, no insert. The pipeline still advances.
//  - Slots holding bubbles do not update the outputs; outputs hold their last values.
//  - rst mid-stream discards all in-flight tags; the first post-reset search sees an empty tree.
//  Other rules:
//  - incoming_tag is ignored when ena=0.
//  - Comparisons are unsigned; there is no wrap-around handling (0 is the minimum tag).
// TESTING
//  1 Reset, then accept 004,012,011,013,014,014,012,100,011,0fe back-to-back
//    -> matching_tag = 004,004,004,012,013,014,012,014,011,014.
//    incoming_tag_forward echoes each tag, both appearing 3 cycles after acceptance.
//  2 Continue after one ena=0 cycle (tree kept): 054->014, 0ff->0fe, 101->100, 101->101,
//    000->000 (no predecessor), a00->400 after 400 is inserted, eee->a00.
//  3 Duplicate/self: empty tree, accept f02 then f02 -> first f02 (self-default), second f02 (stored).
//  4 Backtrack across levels: store 0ff, 100; accept 0fe -> no predecessor, 0fe; accept 1a0 -> 100;
//    accept 0ff -> 0ff.
//  5 ena gaps: idle cycles insert nothing and outputs hold; accept 300 after storing only 150
//    -> 150.
//  6 Reset mid-burst: assert rst during stream; outputs 0; next accepted 555 -> 555 (tree empty).

Source files
------------

// File: rtl/multibit_tree_tag_sorter.sv
// multibit_tree_tag_sorter
//   Pipelined predecessor search over a 16-way bitmap tree. Every accepted
//   tag is looked up (largest stored tag <= it) and then inserted.
//   One tree level is resolved per stage, MSB nibble first.
// Ports
//   clk                   rising-edge clock
//   rst                   synchronous active-high reset (tree + pipeline)
//   ena                   accept incoming_tag this cycle
//   incoming_tag          tag to search and insert
//   matching_tag          predecessor of the tag accepted L cycles earlier
//   incoming_tag_forward  that accepted tag, aligned with matching_tag
//
// Hazard handling: level k of a tag is both read and written in the same
// stage k. A tag accepted earlier has therefore always written level k
// before a younger tag reads it. A tag accepted later has not yet written
// it. So every lookup sees exactly the tags accepted before it, and no
// forwarding is needed.
module multibit_tree_tag_sorter #(
  parameter int T = 12
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ena,
  input  logic [T-1:0] incoming_tag,
  output logic [T-1:0] matching_tag,
  output logic [T-1:0] incoming_tag_forward
);
  localparam int L = T / 4;

  // eq    : a stored prefix still equals the tag's prefix
  // alt   : best prefix strictly below the tag; nibbles not yet resolved are 0
  typedef struct packed {
    logic [T-1:0] tag;
    logic         eq;
    logic         alt_v;
    logic [T-1:0] alt;
  } st_t;

  st_t  [L-1:0] st_q;
  st_t  [L-1:0] nx;
  logic [L-1:0] vld_pipe_q;
  logic [T-1:0] match_q, fwd_q, res;

  // Returns {found, idx}: the highest set bit of v with index < lim.
  function automatic logic [4:0] hi_below(input logic [15:0] v, input logic [4:0] lim);
    logic [4:0] r;
    r = '0;
    for (int i = 0; i < 16; i++)
      if (v[i] && (5'(i) < lim)) r = {1'b1, 4'(i)};
    return r;
  endfunction

  for (genvar k = 0; k < L; k++) begin : g_lvl
    localparam int LO = T - 4*k - 4;
    localparam logic [T-1:0] ONE = T'(1);
    // Keeps only the nibbles above level k.
    localparam logic [T-1:0] HI_MASK = ~((ONE << (LO + 4)) - ONE);

    logic [3:0]  nib;
    logic [15:0] eq_bm, alt_bm;
    logic [4:0]  lt, mx;
    st_t         n_d;

    assign nib = st_q[k].tag[LO +: 4];

    if (k == 0) begin : g_root
      logic [15:0] bm_q;
      always_ff @(posedge clk) begin
        if (rst)                bm_q <= '0;
        else if (vld_pipe_q[0]) bm_q[nib] <= 1'b1;
      end
      assign eq_bm  = bm_q;
      assign alt_bm = bm_q;
    end else begin : g_node
      logic [15:0]    bm_q [16**k];
      logic [4*k-1:0] eq_idx, alt_idx;
      assign eq_idx  = st_q[k].tag[T-1 -: 4*k];
      assign alt_idx = st_q[k].alt[T-1 -: 4*k];
      always_ff @(posedge clk) begin
        if (rst) begin
          for (int i = 0; i < 16**k; i++) bm_q[i] <= '0;
        end else if (vld_pipe_q[k]) begin
          bm_q[eq_idx][nib] <= 1'b1;
        end
      end
      assign eq_bm  = bm_q[eq_idx];
      assign alt_bm = bm_q[alt_idx];
    end

    always_comb begin
      lt  = hi_below(eq_bm, {1'b0, nib});
      mx  = hi_below(alt_bm, 5'd16);
      n_d = st_q[k];
      if (st_q[k].eq) begin
        n_d.eq = eq_bm[nib];
        if (lt[4]) begin
          // A sibling below the path at a deeper level always beats an older alt.
          n_d.alt_v = 1'b1;
          n_d.alt   = (st_q[k].tag & HI_MASK) | ({{(T-4){1'b0}}, lt[3:0]} << LO);
        end else if (st_q[k].alt_v) begin
          n_d.alt[LO +: 4] = mx[3:0];
        end
      end else if (st_q[k].alt_v) begin
        // Max descent under the backtrack point; that subtree is never empty.
        n_d.alt[LO +: 4] = mx[3:0];
      end
    end

    assign nx[k] = n_d;
  end

  // An exact hit and an empty result both report the tag itself.
  always_comb begin
    res = nx[L-1].tag;
    if (!nx[L-1].eq && nx[L-1].alt_v) res = nx[L-1].alt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe_q <= '0;
      st_q       <= '0;
      match_q    <= '0;
      fwd_q      <= '0;
    end else begin
      vld_pipe_q[0] <= ena;
      if (ena) st_q[0] <= '{tag: incoming_tag, eq: 1'b1, alt_v: 1'b0, alt: '0};
      for (int k = 1; k < L; k++) begin
        vld_pipe_q[k] <= vld_pipe_q[k-1];
        st_q[k]       <= nx[k-1];
      end
      // Bubbles leave the outputs holding their last values.
      if (vld_pipe_q[L-1]) begin
        match_q <= res;
        fwd_q   <= nx[L-1].tag;
      end
    end
  end

  assign matching_tag         = match_q;
  assign incoming_tag_forward = fwd_q;
endmodule

// File: tb/tb_multibit_tree_tag_sorter.sv
// Bench for multibit_tree_tag_sorter: directed scenarios plus random
// traffic, checked against a flat "set of stored tags" reference model.
module tb_multibit_tree_tag_sorter;
  logic        clk = 1'b0;
  logic        rst, ena;
  logic [11:0] in_tag, m_tag, f_tag;

  always #5 clk = ~clk;

  multibit_tree_tag_sorter #(.T(12)) dut (
    .clk(clk), .rst(rst), .ena(ena), .incoming_tag(in_tag),
    .matching_tag(m_tag), .incoming_tag_forward(f_tag)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference: a plain membership table plus a 3-deep output delay line.
  bit          stored [4096];
  bit          dv [3];
  logic [11:0] dt [3];
  logic [11:0] dm [3];
  logic [11:0] exp_m, exp_f;

  task automatic chk(input string name, input logic [11:0] got, input logic [11:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %03h expected %03h", name, $time, got, exp);
    end
  endtask

  function automatic logic [11:0] pred(input logic [11:0] x);
    for (int v = int'(x); v >= 0; v--)
      if (stored[v]) return 12'(v);
    return x;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 4096; i++) stored[i] = 1'b0;
    for (int i = 0; i < 3; i++) begin dv[i] = 1'b0; dt[i] = '0; dm[i] = '0; end
    exp_m = '0;
    exp_f = '0;
  endtask

  // One clock: drive, clock, update the model, then compare away from the edge.
  task automatic step(input bit r, input bit e, input logic [11:0] t);
    rst = r; ena = e; in_tag = t;
    @(posedge clk);
    if (r) begin
      model_clear();
    end else begin
      if (dv[2]) begin exp_m = dm[2]; exp_f = dt[2]; end
      dv[2] = dv[1]; dt[2] = dt[1]; dm[2] = dm[1];
      dv[1] = dv[0]; dt[1] = dt[0]; dm[1] = dm[0];
      dv[0] = e;
      if (e) begin
        dt[0] = t;
        dm[0] = pred(t);
        stored[t] = 1'b1;
      end
    end
    #1;
    chk(r ? "rst_match" : "match", m_tag, exp_m);
    chk(r ? "rst_fwd"   : "fwd",   f_tag, exp_f);
  endtask

  task automatic run(input logic [11:0] q[$]);
    foreach (q[i]) step(1'b0, 1'b1, q[i]);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 12'($urandom));
  endtask

  initial begin
    model_clear();
    rst = 1'b1; ena = 1'b0; in_tag = '0;
    step(1'b1, 1'b0, '0);
    step(1'b1, 1'b1, 12'h7ab);
    chk("reset_zero", m_tag, 12'h000);

    // Back-to-back burst, then a gap with the tree kept.
    run('{12'h004, 12'h012, 12'h011, 12'h013, 12'h014, 12'h014, 12'h012,
          12'h100, 12'h011, 12'h0fe});
    idle(1);
    run('{12'h054, 12'h0ff, 12'h101, 12'h101, 12'h000, 12'h400, 12'ha00, 12'heee});
    idle(4);
    chk("last_eee", m_tag, 12'ha00);

    // Duplicate on an empty tree.
    step(1'b1, 1'b0, '0);
    run('{12'hf02, 12'hf02});
    idle(4);

    // Backtrack across levels.
    step(1'b1, 1'b0, '0);
    run('{12'h0ff, 12'h100, 12'h0fe, 12'h1a0, 12'h0ff});
    idle(4);

    // Gaps: outputs hold, nothing inserted.
    step(1'b1, 1'b0, '0);
    run('{12'h150});
    idle(6);
    run('{12'h300});
    idle(4);
    chk("gap_300", m_tag, 12'h150);

    // Reset mid-burst discards in-flight tags.
    run('{12'h123, 12'h456, 12'h789});
    step(1'b1, 1'b1, 12'h222);
    run('{12'h555});
    idle(4);
    chk("post_rst_555", m_tag, 12'h555);

    // Random traffic: mixed ranges to force hits, near misses and backtracks.
    for (int i = 0; i < 4000; i++) begin
      logic [11:0] t;
      case ($urandom_range(0, 3))
        0:       t = 12'($urandom);
        1:       t = 12'h100 + 12'($urandom_range(0, 63));
        2:       t = {4'($urandom), 8'h00} | 12'($urandom_range(0, 3));
        default: t = {4'($urandom_range(0, 2)), 4'($urandom), 4'($urandom_range(14, 15))};
      endcase
      step($urandom_range(0, 299) == 0, $urandom_range(0, 3) != 0, t);
    end
    idle(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
